// File: rtl/mips_instr_loader.sv
// Program loader: encodes symbolic MIPS instructions into 32-bit machine words
// and writes them to consecutive instruction-memory addresses with ack back-pressure.
`timescale 1ns/1ps
module mips_instr_loader #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_class,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  written
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    state_e            state_q,     state_d;
    logic [ADDR_W-1:0] cur_addr_q,  cur_addr_d;
    logic [CNT_W-1:0]  target_q,    target_d;
    logic [CNT_W-1:0]  written_q,   written_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0]  written_inc_s;

    function automatic logic [31:0] encode(
        input logic [2:0]  cls,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [15:0] imm
    );
        logic [31:0] word;
        case (cls)
            3'd0:    word = {6'h00, rs, rt, rd, 5'b00000, 6'h20};
            3'd1:    word = {6'h00, rs, rt, rd, 5'b00000, 6'h22};
            3'd2:    word = {6'h00, rs, rt, rd, 5'b00000, 6'h24};
            3'd3:    word = {6'h00, rs, rt, rd, 5'b00000, 6'h25};
            3'd4:    word = {6'h00, rs, rt, rd, 5'b00000, 6'h2A};
            3'd5:    word = {6'h23, rs, rt, imm};
            3'd6:    word = {6'h2B, rs, rt, imm};
            3'd7:    word = {6'h04, rs, rt, imm};
            default: word = 32'h0000_0000;
        endcase
        return word;
    endfunction

    assign written_inc_s = written_q + CNT_W'(1);

    // Next-state and datapath update for the load sequencer
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        target_d    = target_q;
        written_d   = written_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cur_addr_d = base_addr;
                    target_d   = count;
                    written_d  = CNT_W'(0);
                    if (count != CNT_W'(0)) begin
                        state_d = ST_ACCEPT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCEPT: begin
                if (in_valid) begin
                    mem_wdata_d = encode(in_class, in_rs, in_rt, in_rd, in_imm);
                    mem_addr_d  = cur_addr_q;
                    mem_we_d    = 1'b1;
                    state_d     = ST_WRITE;
                end else begin
                    state_d = ST_ACCEPT;
                end
            end
            ST_WRITE: begin
                // request is held until the memory acknowledges it
                if (mem_ack) begin
                    mem_we_d   = 1'b0;
                    cur_addr_d = cur_addr_q + ADDR_W'(1);
                    written_d  = written_inc_s;
                    if (written_inc_s == target_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ACCEPT;
                    end
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                mem_we_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cur_addr_q  <= ADDR_W'(0);
            target_q    <= CNT_W'(0);
            written_q   <= CNT_W'(0);
            mem_we_q    <= 1'b0;
            mem_addr_q  <= ADDR_W'(0);
            mem_wdata_q <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            target_q    <= target_d;
            written_q   <= written_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign in_ready  = (state_q == ST_ACCEPT);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign written   = written_q;

endmodule

// File: tb/tb_mips_instr_loader.sv
// Randomised scoreboard bench for mips_instr_loader: stimulus pushes expected
// writes/done results, a negedge monitor compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_mips_instr_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  base_addr = 8'h00;
    logic [7:0]  count = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_class = 3'd0;
    logic [4:0]  in_rs = 5'd0, in_rt = 5'd0, in_rd = 5'd0;
    logic [15:0] in_imm = 16'h0000;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic        busy, done;
    logic [7:0]  written;

    int checks = 0;
    int errors = 0;
    logic [7:0]  exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    int          exp_done_q[$];
    int          ack_mode = 0;
    int          done_cnt = 0;
    int          exp_done_total = 0;
    logic [7:0]  next_addr = 8'h00;

    mips_instr_loader #(.ADDR_W(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
        .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class), .in_rs(in_rs),
        .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .busy(busy), .done(done), .written(written)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Reference encoder: field positions and opcode/funct values of the MIPS ISA
    function automatic logic [31:0] ref_word(input int cls, input int rs, input int rt,
                                             input int rd, input int imm);
        longint w;
        longint op;
        if (cls < 5) begin
            case (cls)
                0: op = 32; 1: op = 34; 2: op = 36; 3: op = 37; default: op = 42;
            endcase
            w = longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(rd) * 2048 + op;
        end else begin
            op = (cls == 5) ? 35 : (cls == 6) ? 43 : 4;
            w = op * 67108864 + longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(imm);
        end
        return w[31:0];
    endfunction

    // Monitor: compares writes and done pulses, and plays the memory's ack
    logic        seen = 1'b0;
    logic [7:0]  cur_a = 8'h00;
    logic [31:0] cur_d = 32'h0;
    int          hold = 0;
    logic        prev_done = 1'b0;
    int          exp_w;
    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 1'b0; hold = 0; prev_done = 1'b0; mem_ack = 1'b0;
        end else begin
            if (mem_we) begin
                if (!seen) begin
                    checks++;
                    if (exp_addr_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write addr=0x%02h data=0x%08h required=no write",
                                 mem_addr, mem_wdata);
                        cur_a = mem_addr; cur_d = mem_wdata;
                    end else begin
                        cur_a = exp_addr_q.pop_front();
                        cur_d = exp_data_q.pop_front();
                        chk("write_addr", 32'(mem_addr), 32'(cur_a));
                        chk("write_data", mem_wdata, cur_d);
                    end
                    seen = 1'b1; hold = 0;
                end else begin
                    chk("hold_addr", 32'(mem_addr), 32'(cur_a));
                    chk("hold_data", mem_wdata, cur_d);
                end
                chk("ready_in_write", 32'(in_ready), 32'd0);
                case (ack_mode)
                    0:       mem_ack = 1'b1;
                    1:       mem_ack = ($urandom_range(0, 3) != 0);
                    2:       mem_ack = (hold >= 3);
                    default: mem_ack = 1'b0;
                endcase
                hold++;
                if (mem_ack) seen = 1'b0;
            end else begin
                seen = 1'b0;
                mem_ack = 1'($urandom_range(0, 1));
            end
            if (done) begin
                checks++;
                if (exp_done_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done written=%0d required=no done", written);
                end else begin
                    exp_w = exp_done_q.pop_front();
                    chk("written_at_done", 32'(written), 32'(exp_w));
                    chk("writes_pending_at_done", 32'(exp_addr_q.size()), 32'd0);
                end
                chk("done_single_cycle", 32'(prev_done), 32'd0);
                chk("busy_in_done", 32'(busy), 32'd1);
                done_cnt++;
            end
            prev_done = done;
        end
    end

    task automatic push_exp(input logic [31:0] data);
        exp_addr_q.push_back(next_addr);
        exp_data_q.push_back(data);
        next_addr = next_addr + 8'd1;
    endtask

    task automatic do_start(input logic [7:0] b, input logic [7:0] c);
        next_addr = b;
        exp_done_q.push_back(int'(c));
        exp_done_total++;
        start = 1'b1; base_addr = b; count = c;
        @(negedge clk);
        start = 1'b0; base_addr = 8'($urandom); count = 8'($urandom);
    endtask

    task automatic send(input logic [2:0] c, input logic [4:0] s, input logic [4:0] t,
                        input logic [4:0] d, input logic [15:0] im);
        logic r;
        logic ok;
        ok = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        in_valid = 1'b1; in_class = c; in_rs = s; in_rt = t; in_rd = d; in_imm = im;
        for (int i = 0; i < 200; i++) begin
            r = in_ready;
            @(posedge clk);
            if (r) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_class = 3'($urandom); in_rs = 5'($urandom); in_rt = 5'($urandom);
        in_rd = 5'($urandom); in_imm = 16'($urandom);
        chk("send_accepted", 32'(ok), 32'd1);
    endtask

    task automatic issue_rand();
        int c, s, t, d, im;
        c = $urandom_range(0, 7); s = $urandom_range(0, 31); t = $urandom_range(0, 31);
        d = $urandom_range(0, 31); im = $urandom_range(0, 65535);
        push_exp(ref_word(c, s, t, d, im));
        send(3'(c), 5'(s), 5'(t), 5'(d), 16'(im));
    endtask

    task automatic wait_done(input int exp_written);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt >= exp_done_total) begin ok = 1'b1; break; end
        end
        chk("done_seen", 32'(ok), 32'd1);
        @(negedge clk);
        #1;
        chk("idle_after_done", 32'(busy), 32'd0);
        chk("done_low_after", 32'(done), 32'd0);
        chk("written_holds", 32'(written), 32'(exp_written));
    endtask

    task automatic rand_load(input logic [7:0] b, input int n);
        do_start(b, 8'(n));
        for (int k = 0; k < n; k++) issue_rand();
        wait_done(n);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_written"}, 32'(written), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Asynchronous reset asserted in the middle of a clock phase
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // in_valid while idle must not produce a write
        in_valid = 1'b1; in_class = 3'd5; in_rs = 5'd3; in_imm = 16'h1234;
        repeat (3) @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;

        // Directed program
        ack_mode = 0;
        do_start(8'h10, 8'd4);
        push_exp(32'h0022_1820); send(3'd0, 5'd1, 5'd2, 5'd3, 16'($urandom));
        push_exp(32'h8FA8_0004); send(3'd5, 5'd29, 5'd8, 5'($urandom), 16'h0004);
        push_exp(32'h1022_FFFF); send(3'd7, 5'd1, 5'd2, 5'($urandom), 16'hFFFF);
        push_exp(32'hAC09_0000); send(3'd6, 5'd0, 5'd9, 5'($urandom), 16'h0000);
        wait_done(4);

        // Back-pressure: ack withheld for three cycles per write
        ack_mode = 2;
        rand_load(8'h40, 2);
        ack_mode = 0;

        // Address wrap
        do_start(8'hFF, 8'd2);
        push_exp(32'h00C7_282A); send(3'd4, 5'd6, 5'd7, 5'd5, 16'($urandom));
        push_exp(32'h0043_0825); send(3'd3, 5'd2, 5'd3, 5'd1, 16'($urandom));
        wait_done(2);

        // Zero count
        do_start(8'h55, 8'd0);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_no_write", 32'(mem_we), 32'd0);
        wait_done(0);

        // Start while busy is ignored
        do_start(8'h20, 8'd3);
        start = 1'b1; base_addr = 8'h99; count = 8'd1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) issue_rand();
        wait_done(3);

        // Randomised loads with random ack timing
        ack_mode = 1;
        for (int j = 0; j < 6; j++) rand_load(8'($urandom), $urandom_range(1, 5));

        // Reset in the middle of a pending write
        ack_mode = 3;
        do_start(8'h30, 8'd3);
        push_exp(ref_word(1, 4, 5, 6, 0));
        send(3'd1, 5'd4, 5'd5, 5'd6, 16'h0000);
        @(negedge clk);
        chk("write_pending_before_reset", 32'(mem_we), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        exp_addr_q.delete(); exp_data_q.delete(); exp_done_q.delete();
        exp_done_total = done_cnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ack_mode = 0;
        repeat (3) @(negedge clk);
        rand_load(8'h80, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_instr_loader.md
Name: mips_instr_loader

Overview:
- Encoder counterpart to the single-cycle control/decoder path.
- Accepts symbolic instructions (class plus register/immediate fields) over a valid/ready handshake and encodes each into a 32-bit MIPS machine word.
- Writes the words into instruction memory at consecutive word addresses, with memory back-pressure via an ack.
- Used to load test programs into the instruction memory ahead of CPU execution.

Parameters:
ADDR_W, 8, width of instruction-memory word address
CNT_W, 8, width of instruction count and written counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse that begins a load; ignored while busy=1
base_addr  in  ADDR_W  first word address, sampled on accepted start
count  in  CNT_W  number of instructions to load, sampled on accepted start
in_valid  in  1  instruction fields valid
in_ready  out  1  loader can accept an instruction this cycle
in_class  in  3  0 add, 1 sub, 2 and, 3 or, 4 slt, 5 lw, 6 sw, 7 beq
in_rs  in  5  rs field
in_rt  in  5  rt field
in_rd  in  5  rd field (R-type only)
in_imm  in  16  immediate/offset (I-type only)
mem_we  out  1  memory write request
mem_addr  out  ADDR_W  write word address
mem_wdata  out  32  encoded instruction word
mem_ack  in  1  memory accepted the write this cycle
busy  out  1  load in progress (state != IDLE)
done  out  1  one-cycle pulse when the load completes
written  out  CNT_W  words written in current/last load

Behaviour:
- Reset (async, rst_n=0): state=IDLE; mem_we=0, mem_addr=0, mem_wdata=0, done=0, written=0, busy=0, in_ready=0; internal cur_addr=0, target=0. Reset mid-write aborts immediately with no further writes.
- Encoding:
  - R-type (class 0-4): {6'h00, rs, rt, rd, 5'b0, funct}, where funct is add=0x20, sub=0x22, and=0x24, or=0x25, slt=0x2A.
  - I-type: {op, rs, rt, imm}, where op is lw=0x23, sw=0x2B, beq=0x04; in_rd is ignored.
  - R-type ignores in_imm.
  - All 8 classes are legal.
- FSM states: IDLE, ACCEPT, WRITE, DONE.
- IDLE:
  - On start: latch base_addr into cur_addr and count into target; clear written.
  - If count!=0, go to ACCEPT; if count==0, go to DONE.
- ACCEPT:
  - in_ready=1 (decoded from state register only).
  - On in_valid: register the encoded word into mem_wdata, cur_addr into mem_addr, set mem_we=1, go to WRITE.
  - If accepted at edge k, mem_we is high in the cycle after k.
- WRITE:
  - in_ready=0; mem_we, mem_addr and mem_wdata stay stable until the edge where mem_ack=1.
  - At that edge: mem_we=0, cur_addr=cur_addr+1 (mod 2^ADDR_W, wraps 0xFF->0x00), written=written+1.
  - If written+1==target, go to DONE; otherwise go to ACCEPT.
- DONE: done=1 for exactly one cycle, then IDLE. busy=1 in ACCEPT, WRITE and DONE.
- mem_ack is ignored outside WRITE. start is ignored when busy=1. in_valid is ignored outside ACCEPT.
- Peak throughput is one word per 2 cycles (mem_ack tied high).
- written holds its final value in IDLE until the next accepted start.

Test Plan:
- Reset: assert rst_n=0 mid-clock -> all outputs 0 immediately, state IDLE, in_ready=0.
- Encode program: start base=0x10, count=4; send add $3,$1,$2; lw $8,4($29); beq $1,$2,-1; sw $9,0($0); mem_ack=1.
  - Required writes: 0x10:0x00221820, 0x11:0x8FA80004, 0x12:0x1022FFFF, 0x13:0xAC090000.
  - Then done pulse for 1 cycle, written=4.
- Back-pressure: hold mem_ack=0 for 3 cycles during a write -> mem_we/addr/data stable, in_ready=0; completes on the ack edge.
- Wrap: base=0xFF, count=2 (slt $5,$6,$7 then or $1,$2,$3) -> writes to 0xFF:0x00C7282A then 0x00:0x00430825.
- Zero count and ignored start: start count=0 -> done high in the next cycle, no mem_we. start pulse while busy -> no effect on target/addr.
- Reset mid-load: drop rst_n while mem_we=1 -> mem_we=0 at once. A new start after release loads cleanly from the new base_addr.
